// File: rtl/sample_frame_pkg.sv
// rtl/sample_frame_pkg.sv - shared types, constants and helpers for the sample frame scheduler
// Purpose: FSM state type, frame byte constants, byte encoder and the
//          "next enabled channel" priority search used by sample_frame_sched.
// Ports:   none (package).
package sample_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] SYNC0   = 8'h43;
  localparam logic [7:0] SYNC1   = 8'h48;
  localparam logic [7:0] CH_BASE = 8'h30;
  localparam int         FRAME_BYTES = 5;

  // Byte bidx of the frame for channel ch carrying sample s.
  function automatic logic [7:0] frame_byte(input logic [1:0] ch,
                                            input logic [2:0] bidx,
                                            input logic [15:0] s);
    logic [7:0] b;
    case (bidx)
      3'd0:    b = SYNC0;
      3'd1:    b = SYNC1;
      3'd2:    b = CH_BASE + {6'd0, ch};
      3'd3:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction

  // Lowest set bit of mask at index >= from. Result bit 2 = found, [1:0] = index.
  // from may be 4 (search past channel 3), which yields "not found".
  function automatic logic [2:0] next_enabled(input logic [3:0] mask,
                                              input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_frame_sched_if.sv
// rtl/sample_frame_sched_if.sv - byte start/busy handshake between the scheduler and uart_tx
// Purpose: groups the transmitter handshake into one bundle.
// Signals: tx_start (1-cycle byte start), tx_data (byte, valid with tx_start),
//          tx_busy (transmitter busy, returned by uart_tx).
// Modports: master = scheduler side, slave = transmitter side.
interface sample_frame_sched_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/sample_frame_sched_strobe_decim.sv
// rtl/sample_frame_sched_strobe_decim.sv - sample_clk rising-edge detector with decimation counter
// Purpose: turns the level sample_clk into a one-cycle due pulse on every
//          DECIMATE-th rising edge (the first edge after reset is due).
// Ports:   clk, rst (sync, active high), sample_clk_i (level strobe),
//          due_o (combinational one-cycle pulse in the rising-edge cycle).
module strobe_decim #(
  parameter int DECIMATE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_clk_i,
  output logic due_o
);

  localparam logic [15:0] LAST = 16'(DECIMATE - 1);

  logic        sc_q;
  logic [15:0] dcnt_q;
  logic [15:0] dcnt_d;
  logic        rise;

  always_comb begin
    rise   = sample_clk_i & ~sc_q;
    due_o  = rise & (dcnt_q == 16'd0);
    dcnt_d = dcnt_q;
    if (rise) dcnt_d = (dcnt_q == LAST) ? 16'd0 : dcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q   <= 1'b0;
      dcnt_q <= 16'd0;
    end else begin
      sc_q   <= sample_clk_i;
      dcnt_q <= dcnt_d;
    end
  end

endmodule

// File: rtl/sample_frame_sched.sv
// rtl/sample_frame_sched.sv - framed sample telemetry sequencer driving uart_tx
// Purpose: on each due sample_clk edge snapshot four channels and send, per
//          enabled channel in ascending order, 'C','H','0'+ch,MSB,LSB.
//          Due edges arriving while a frame is in flight are dropped and counted.
// Ports:   clk, rst (sync, active high), sample_clk, sample_in0..3 (signed
//          samples), ch_mask (channel enables), tx (master handshake to
//          uart_tx), frame_done / overrun (1-cycle pulses), drop_count
//          (saturating), active (frame in progress). All outputs registered.
module sample_frame_sched
  import sample_frame_pkg::*;
#(
  parameter int W        = 16,
  parameter int DECIMATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic [W-1:0]        sample_in0,
  input  logic [W-1:0]        sample_in1,
  input  logic [W-1:0]        sample_in2,
  input  logic [W-1:0]        sample_in3,
  input  logic [3:0]          ch_mask,
  sample_frame_sched_if.master tx,
  output logic                frame_done,
  output logic                overrun,
  output logic [15:0]         drop_count,
  output logic                active
);

  logic due;

  strobe_decim #(.DECIMATE(DECIMATE)) u_decim (
    .clk          (clk),
    .rst          (rst),
    .sample_clk_i (sample_clk),
    .due_o        (due)
  );

  state_t              state_q, state_d;
  logic [3:0][W-1:0]   shadow_q, shadow_d;
  logic [3:0]          smask_q, smask_d;
  logic [1:0]          ch_q, ch_d;
  logic [2:0]          bidx_q, bidx_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         drop_q, drop_d;
  logic                active_q, active_d;
  logic [2:0]          first_ch;
  logic [2:0]          higher_ch;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    smask_d      = smask_q;
    ch_d         = ch_q;
    bidx_d       = bidx_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    drop_d       = drop_q;
    first_ch     = next_enabled(ch_mask, 3'd0);
    higher_ch    = next_enabled(smask_q, {1'b0, ch_q} + 3'd1);

    case (state_q)
      IDLE: begin
        // A due edge with no channels enabled is simply ignored.
        if (due && (ch_mask != 4'd0)) begin
          shadow_d = {sample_in3, sample_in2, sample_in1, sample_in0};
          smask_d  = ch_mask;
          ch_d     = first_ch[1:0];
          bidx_d   = 3'd0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (!tx.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte(ch_q, bidx_q, 16'(shadow_q[ch_q]));
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bidx_q < 3'(FRAME_BYTES - 1)) begin
          bidx_d  = bidx_q + 3'd1;
          state_d = WAIT;
        end else if (higher_ch[2]) begin
          ch_d    = higher_ch[1:0];
          bidx_d  = 3'd0;
          state_d = WAIT;
        end else begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any due edge outside IDLE is dropped, including the HOLD->IDLE cycle.
    if (due && (state_q != IDLE)) begin
      overrun_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      smask_q      <= 4'd0;
      ch_q         <= 2'd0;
      bidx_q       <= 3'd0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      drop_q       <= 16'd0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      smask_q      <= smask_d;
      ch_q         <= ch_d;
      bidx_q       <= bidx_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      drop_q       <= drop_d;
      active_q     <= active_d;
    end
  end

  assign tx.tx_start  = tx_start_q;
  assign tx.tx_data   = tx_data_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;
  assign drop_count   = drop_q;
  assign active       = active_q;

endmodule

// File: tb/tb_sample_frame_sched.sv
// tb/tb_sample_frame_sched.sv - self-checking bench for sample_frame_sched
module tb_sample_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_clk = 1'b0;
  logic        sample_clk2 = 1'b0;
  logic [15:0] in0 = 16'h0, in1 = 16'h0, in2 = 16'h0, in3 = 16'h0;
  logic [3:0]  mask = 4'h0;

  logic        frame_done, overrun, active;
  logic [15:0] drop_count;
  logic        frame_done2, overrun2, active2;
  logic [15:0] drop_count2;

  int checks = 0;
  int failures = 0;

  sample_frame_sched_if tx_if ();
  sample_frame_sched_if tx2_if ();

  sample_frame_sched #(.W(16), .DECIMATE(1)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .ch_mask(mask), .tx(tx_if),
    .frame_done(frame_done), .overrun(overrun), .drop_count(drop_count), .active(active)
  );

  sample_frame_sched #(.W(16), .DECIMATE(3)) dut2 (
    .clk(clk), .rst(rst), .sample_clk(sample_clk2),
    .sample_in0(in0), .sample_in1(in1), .sample_in2(in2), .sample_in3(in3),
    .ch_mask(mask), .tx(tx2_if),
    .frame_done(frame_done2), .overrun(overrun2), .drop_count(drop_count2), .active(active2)
  );

  always #5 clk = ~clk;

  // uart_tx model for dut: busy for busy_len cycles after each start.
  int         busy_len = 10;
  int         busy_cnt = 0;
  logic       busy_stuck = 1'b0;
  logic [7:0] bytes_q[$];
  int         coll = 0, ovr_cnt = 0, fd_cnt = 0, fd_act_bad = 0;

  assign tx_if.tx_busy = busy_stuck || (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_if.tx_start) begin
      bytes_q.push_back(tx_if.tx_data);
      if (tx_if.tx_busy) coll <= coll + 1;
      busy_cnt <= busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      if (active) fd_act_bad <= fd_act_bad + 1;
    end
  end

  // Fast uart_tx model for dut2.
  int         busy2_cnt = 0;
  logic [7:0] bytes2_q[$];
  int         coll2 = 0;

  assign tx2_if.tx_busy = (busy2_cnt != 0);

  always @(posedge clk) begin
    if (tx2_if.tx_start) begin
      bytes2_q.push_back(tx2_if.tx_data);
      if (tx2_if.tx_busy) coll2 <= coll2 + 1;
      busy2_cnt <= 2;
    end else if (busy2_cnt != 0) begin
      busy2_cnt <= busy2_cnt - 1;
    end
  end

  // Reference model: expected byte stream built from the frame format.
  logic [7:0] exp_q[$];
  int         exp_drops = 0;

  task automatic add_frame(input logic [3:0] m, input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] s2, input logic [15:0] s3);
    logic [15:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h30 + 8'(c));
        exp_q.push_back(s[c][15:8]);
        exp_q.push_back(s[c][7:0]);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rise();
    sample_clk = 1'b1;
    @(negedge clk);
    sample_clk = 1'b0;
    @(negedge clk);
  endtask

  // Waits for fd_cnt to reach target; returns 0 if the cycle budget ran out.
  task automatic wait_frames(input int target, input int budget, output bit ok);
    int c;
    c = 0;
    while (fd_cnt < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (fd_cnt >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    checks++;
    if ({tx_if.tx_start, tx_if.tx_data, frame_done, overrun, active} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=000",
               {tx_if.tx_start, tx_if.tx_data, frame_done, overrun, active});
    end
    checks++;
    if (drop_count !== 16'h0 || drop_count2 !== 16'h0) begin
      failures++;
      $display("FAIL reset_drop_count got=%h/%h want=0000/0000", drop_count, drop_count2);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_full_frame();
    logic [7:0] plan [20];
    bit ok;
    int bad;
    plan = '{8'h43, 8'h48, 8'h30, 8'h12, 8'h34, 8'h43, 8'h48, 8'h31, 8'h80, 8'h00,
             8'h43, 8'h48, 8'h32, 8'h7F, 8'hFF, 8'h43, 8'h48, 8'h33, 8'hFF, 8'hFF};
    busy_len = 10;
    in0 = 16'h1234; in1 = 16'h8000; in2 = 16'h7FFF; in3 = 16'hFFFF; mask = 4'hF;
    bytes_q.delete();
    sample_clk = 1'b1;
    @(negedge clk);
    checks++;
    if (active !== 1'b1 || tx_if.tx_start !== 1'b0) begin
      failures++;
      $display("FAIL e1_active got=%b/%b want=1/0", active, tx_if.tx_start);
    end
    sample_clk = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_if.tx_start !== 1'b1 || tx_if.tx_data !== 8'h43) begin
      failures++;
      $display("FAIL e2_start got=%b/%h want=1/43", tx_if.tx_start, tx_if.tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_if.tx_start !== 1'b0) begin
      failures++;
      $display("FAIL start_width got=%b want=0", tx_if.tx_start);
    end
    wait_frames(1, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_timeout got=%0d want=1", fd_cnt); end
    tick(busy_len + 5);
    checks++;
    if (bytes_q.size() != 20) begin
      failures++;
      $display("FAIL full_count got=%0d want=20", bytes_q.size());
    end
    bad = 0;
    for (int i = 0; i < 20 && i < bytes_q.size(); i++) if (bytes_q[i] !== plan[i]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL full_bytes got=%0d_wrong want=0_wrong", bad); end
    checks++;
    if (fd_cnt != 1 || fd_act_bad != 0) begin
      failures++;
      $display("FAIL full_done got=%0d/%0d want=1/0", fd_cnt, fd_act_bad);
    end
  endtask

  task automatic test_partial_mask();
    bit ok;
    int bad, base;
    base = fd_cnt;
    in1 = 16'h00A5; in3 = 16'($urandom); in0 = 16'hDEAD; in2 = 16'hBEEF; mask = 4'b1010;
    bytes_q.delete(); exp_q.delete();
    add_frame(4'b1010, in0, in1, in2, in3);
    pulse_rise();
    wait_frames(base + 1, 1000, ok);
    tick(busy_len + 5);
    checks++;
    if (!ok || bytes_q.size() != 10) begin
      failures++;
      $display("FAIL partial_count got=%0d want=10", bytes_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++) if (bytes_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || bytes_q[3] !== 8'h00 || bytes_q[4] !== 8'hA5) begin
      failures++;
      $display("FAIL partial_bytes got=%0d_wrong want=0_wrong", bad);
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    int bad, base;
    logic [3:0] m;
    logic [15:0] s0, s1, s2, s3;
    for (int it = 0; it < 6; it++) begin
      base = fd_cnt;
      busy_len = $urandom_range(1, 12);
      m = 4'($urandom_range(1, 15));
      s0 = 16'($urandom); s1 = 16'($urandom); s2 = 16'($urandom); s3 = 16'($urandom);
      in0 = s0; in1 = s1; in2 = s2; in3 = s3; mask = m;
      bytes_q.delete(); exp_q.delete();
      add_frame(m, s0, s1, s2, s3);
      pulse_rise();
      // Mid-frame input changes must not reach the frame.
      tick($urandom_range(1, 6));
      mask = 4'($urandom); in0 = ~s0; in1 = ~s1; in2 = ~s2; in3 = ~s3;
      wait_frames(base + 1, 2000, ok);
      tick(busy_len + 5);
      checks++;
      if (!ok || bytes_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d want=%0d", it, bytes_q.size(), exp_q.size());
      end
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++) if (bytes_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rand%0d_bytes got=%0d_wrong want=0_wrong", it, bad); end
    end
    checks++;
    if (drop_count !== 16'(exp_drops) || coll != 0) begin
      failures++;
      $display("FAIL rand_drops got=%0d/%0d want=%0d/0", drop_count, coll, exp_drops);
    end
  endtask

  task automatic test_mask_zero();
    int base;
    bit saw_active;
    base = fd_cnt;
    mask = 4'h0;
    bytes_q.delete();
    saw_active = 1'b0;
    sample_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      sample_clk = 1'b0;
      if (active) saw_active = 1'b1;
    end
    checks++;
    if (saw_active || bytes_q.size() != 0 || fd_cnt != base || drop_count !== 16'(exp_drops)) begin
      failures++;
      $display("FAIL mask_zero got=act%b/bytes%0d/fd%0d/drop%0d want=act0/bytes0/fd%0d/drop%0d",
               saw_active, bytes_q.size(), fd_cnt, drop_count, base, exp_drops);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int bad, base, ovr_base;
    base = fd_cnt;
    ovr_base = ovr_cnt;
    busy_len = 400;
    in0 = 16'h0102; in1 = 16'h0304; in2 = 16'h0506; in3 = 16'h0708; mask = 4'hF;
    bytes_q.delete(); exp_q.delete();
    add_frame(4'hF, in0, in1, in2, in3);
    // 10 rises 100 cycles apart; a 20-byte frame with 400-cycle busy outlasts them all.
    for (int r = 0; r < 10; r++) begin
      pulse_rise();
      tick(98);
    end
    exp_drops += 9;
    wait_frames(base + 1, 10000, ok);
    tick(busy_len + 5);
    checks++;
    if (!ok || drop_count !== 16'(exp_drops) || ovr_cnt - ovr_base != 9) begin
      failures++;
      $display("FAIL overrun_count got=drop%0d/pulses%0d want=drop%0d/pulses9",
               drop_count, ovr_cnt - ovr_base, exp_drops);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++) if (bytes_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || bytes_q.size() != 20 || coll != 0) begin
      failures++;
      $display("FAIL overrun_bytes got=%0d_wrong/%0d/coll%0d want=0_wrong/20/coll0", bad, bytes_q.size(), coll);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int bad, base, c;
    busy_len = 40;
    in0 = 16'hA1B2; in1 = 16'hC3D4; in2 = 16'hE5F6; in3 = 16'h0718; mask = 4'hF;
    bytes_q.delete();
    pulse_rise();
    c = 0;
    while (bytes_q.size() < 3 && c < 2000) begin @(negedge clk); c++; end
    checks++;
    if (bytes_q.size() < 3 || !tx_if.tx_busy) begin
      failures++;
      $display("FAIL rst_setup got=%0d/%b want=3/1", bytes_q.size(), tx_if.tx_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_if.tx_start, tx_if.tx_data, frame_done, overrun, active, drop_count} !== 28'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h want=0",
               {tx_if.tx_start, tx_if.tx_data, frame_done, overrun, active, drop_count});
    end
    rst = 1'b0;
    exp_drops = 0;
    base = fd_cnt;
    bytes_q.delete(); exp_q.delete();
    add_frame(4'hF, in0, in1, in2, in3);
    pulse_rise();
    wait_frames(base + 1, 5000, ok);
    tick(busy_len + 5);
    checks++;
    if (!ok || coll != 0 || bytes_q.size() != 20) begin
      failures++;
      $display("FAIL rst_restart got=ok%b/coll%0d/bytes%0d want=ok1/coll0/bytes20", ok, coll, bytes_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++) if (bytes_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_bytes got=%0d_wrong want=0_wrong", bad); end
  endtask

  task automatic test_decimate();
    int bad;
    mask = 4'h1;
    in1 = 16'h0; in2 = 16'h0; in3 = 16'h0;
    bytes2_q.delete(); exp_q.delete();
    for (int r = 1; r <= 9; r++) begin
      in0 = 16'(r * 16'h0101);
      if ((r - 1) % 3 == 0) add_frame(4'h1, in0, 16'h0, 16'h0, 16'h0);
      sample_clk2 = 1'b1;
      @(negedge clk);
      sample_clk2 = 1'b0;
      tick(60);
    end
    checks++;
    if (bytes2_q.size() != 15 || drop_count2 !== 16'h0 || coll2 != 0) begin
      failures++;
      $display("FAIL decim_count got=bytes%0d/drop%0d/coll%0d want=bytes15/drop0/coll0",
               bytes2_q.size(), drop_count2, coll2);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < bytes2_q.size(); i++) if (bytes2_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL decim_bytes got=%0d_wrong want=0_wrong", bad); end
  endtask

  task automatic test_saturation();
    bit ok;
    int base, ovr_base, c;
    base = fd_cnt;
    busy_len = 10;
    mask = 4'h1; in0 = 16'h5A5A;
    bytes_q.delete(); exp_q.delete();
    add_frame(4'h1, in0, 16'h0, 16'h0, 16'h0);
    pulse_rise();
    c = 0;
    while (bytes_q.size() < 1 && c < 100) begin @(negedge clk); c++; end
    busy_stuck = 1'b1;
    tick(2);
    force dut.drop_q = 16'hFFFB;
    @(negedge clk);
    release dut.drop_q;
    ovr_base = ovr_cnt;
    repeat (3) pulse_rise();
    tick(2);
    checks++;
    if (drop_count !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_near got=%h want=fffe", drop_count);
    end
    pulse_rise();
    tick(2);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_reach got=%h want=ffff", drop_count);
    end
    repeat (4) pulse_rise();
    tick(2);
    checks++;
    if (drop_count !== 16'hFFFF || ovr_cnt - ovr_base != 8) begin
      failures++;
      $display("FAIL sat_hold got=%h/%0d want=ffff/8", drop_count, ovr_cnt - ovr_base);
    end
    busy_stuck = 1'b0;
    wait_frames(base + 1, 1000, ok);
    tick(busy_len + 5);
    checks++;
    if (!ok || bytes_q.size() != 5 || bytes_q[3] !== 8'h5A || bytes_q[4] !== 8'h5A || coll != 0) begin
      failures++;
      $display("FAIL sat_frame got=ok%b/bytes%0d/coll%0d want=ok1/bytes5/coll0", ok, bytes_q.size(), coll);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_partial_mask();
    test_random_frames();
    test_mask_zero();
    test_overrun();
    test_reset_midframe();
    test_decimate();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
